spi_master_mmio: RTL and testbench
==================================

# spi_master_mmio

Memory-mapped SPI master peripheral that sits directly downstream of the memory controller on the MMIO bus and serves the 0xAAAAA500–0xAAAAA501 window. CPU writes queue bytes into a TX FIFO, a mode-0 shift engine clocks them out on SCLK/MOSI while capturing MISO, and received bytes land in an RX FIFO the CPU drains with loads. Status flags feed the controller's status read path.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range is 1 or greater.
- FIFO_DEPTH, 8: entries per FIFO; must be a power of two, 2 or greater.

Ports:
- clk  in  1  system clock; one clock domain, shared with the memory controller.
- rst  in  1  asynchronous, active-high reset.
- spi_wr  in  1  write strobe, one cycle per store.
- spi_rd  in  1  read strobe, one cycle per load.
- spi_addr  in  1  MMIO address bit 0. 0 selects the data register; 1 selects the status register (new mmio_bus field).
- spi_din  in  8  byte to transmit.
- spi_ignore_response  in  1  when set, the byte received for this transfer is discarded.
- spi_dout  out  8  RX FIFO head (show-ahead).
- spi_buffer_full  out  1  TX FIFO full.
- spi_buffer_empty  out  1  TX FIFO empty and engine idle.
- spi_data_avail  out  1  RX FIFO non-empty.
- sclk  out  1  SPI clock, mode 0.
- mosi  out  1  serial data out, MSB first.
- miso  in  1  serial data in; sampled on SCLK rising.
- cs_n  out  1  chip select, active low.

## Operation
- A write to the data register (spi_wr with spi_addr=0) pushes {spi_ignore_response, spi_din} as a 9-bit entry into the TX FIFO. If the FIFO is full, the write is silently dropped and FIFO state is unchanged.
- A read of the data register (spi_rd with spi_addr=0) pops the RX FIFO when it is non-empty. spi_dout is 8'h00 whenever the RX FIFO is empty. Reads and writes with spi_addr=1 have no side effects.
- Engine FSM states are IDLE, SETUP, HIGH, LOW and DONE.
  - IDLE: sclk=0, cs_n=1. The engine pops the TX head when the TX FIFO is non-empty and one of these holds: the head's ignore bit is 1, or the RX FIFO is not full. It then loads the shift register, drives cs_n=0, drives mosi=bit7, and moves to SETUP. Otherwise it stays in IDLE.
  - SETUP: lasts CLK_DIV cycles, then moves to HIGH.
  - HIGH: sclk=1. MISO is sampled into the RX shift register on entry. Lasts CLK_DIV cycles, then moves to LOW.
  - LOW: sclk=0. On entry mosi takes the next bit. Lasts CLK_DIV cycles. After the 8th bit the FSM moves to DONE; otherwise it returns to HIGH.
  - DONE: lasts 1 cycle. The received byte is pushed to the RX FIFO unless the ignore bit was set. If the TX FIFO is non-empty and the pop condition holds, the engine loads the next byte and returns to SETUP with cs_n held low (back-to-back transfer). Otherwise it drives cs_n=1 and moves to IDLE.
- RX full with a non-ignored head stalls the engine in IDLE; no received data is ever lost.
- A simultaneous push and pop on either FIFO in the same cycle both take effect; the occupancy count is unchanged.
- mosi holds its last value while idle.

## Timing
- Reset values: sclk=0, cs_n=1, mosi=0, spi_dout=8'h00, spi_buffer_full=0, spi_buffer_empty=1, spi_data_avail=0. Both FIFOs are empty and the FSM is in IDLE.
- Reset asserted mid-transfer aborts it immediately. cs_n goes high asynchronously and queued data is discarded.
- Write in cycle 0 → entry visible in cycle 1 → FSM enters SETUP (cs_n low) in cycle 2.
- From SETUP entry to DONE: 17×CLK_DIV cycles. spi_data_avail rises the cycle after DONE.
- spi_dout and all flags are valid combinationally from registered state. The controller captures them on the same edge as spi_rd; the pop takes effect on that edge.
- FIFO flags update on the clock edge following a push or pop.

## Structure
- Package spi_pkg holds:
  - the FSM state enum spi_state_t;
  - the TX entry struct {logic ign; logic [7:0] data};
  - the localparams SPI_DATA_ADDR=1'b0 and SPI_STAT_ADDR=1'b1.
- Sub-module sync_fifo(WIDTH, DEPTH): show-ahead FIFO with asynchronous reset, count-based full/empty flags, and simultaneous push/pop support. It is instantiated twice (TX WIDTH=9, RX WIDTH=8).
- One half-period counter of $clog2(CLK_DIV+1) bits and one 3-bit bit counter.

## Test plan
- Reset, then write 0xA5 with CLK_DIV=2 and MISO looping back MOSI → cs_n falls in cycle 2. MOSI shows 1,0,1,0,0,1,0,1 on SCLK rising edges. spi_data_avail rises in cycle 37, and reading returns 0xA5.
- Write 0x3C with spi_ignore_response=1 → transfer occurs, spi_data_avail stays 0, and spi_buffer_empty returns to 1 after DONE.
- Write FIFO_DEPTH+1 bytes back-to-back while the engine is stalled (RX full) → spi_buffer_full=1 and the extra byte is dropped. After draining RX, exactly FIFO_DEPTH transfers complete with cs_n continuously low.
- Fill RX with FIFO_DEPTH non-ignored bytes and queue one more → the engine stays in IDLE with cs_n=1. One data read restarts it within 2 cycles.
- Assert rst at the 4th SCLK rising edge → cs_n=1 and sclk=0 immediately. Flags return to empty=1, full=0, avail=0, and spi_dout=0x00.
- Read with spi_addr=1 while RX holds 0x11 → the RX count is unchanged, and a subsequent data read returns 0x11.

Source files
------------

// File: rtl/spi_master_mmio_pkg.sv
// Shared types and constants for the MMIO SPI master: engine states, TX FIFO
// entry layout and the register select values on the address bit.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    typedef struct packed {
        logic       ign;
        logic [7:0] data;
    } spi_tx_entry_t;

    localparam logic SPI_DATA_ADDR = 1'b0;
    localparam logic SPI_STAT_ADDR = 1'b1;

endpackage

// File: rtl/spi_master_mmio_if.sv
// MMIO-side bus of the SPI master: load/store strobes from the memory
// controller plus the data/status values it captures.
interface spi_master_mmio_if;
    // spi_wr and spi_rd are single-cycle strobes with no back-pressure: a store
    // that finds the TX FIFO full is dropped, a load of an empty RX FIFO is a no-op.
    logic       spi_wr;
    logic       spi_rd;
    logic       spi_addr;
    logic [7:0] spi_din;
    logic       spi_ignore_response;
    logic [7:0] spi_dout;
    logic       spi_buffer_full;
    logic       spi_buffer_empty;
    logic       spi_data_avail;

    modport master (
        output spi_wr, spi_rd, spi_addr, spi_din, spi_ignore_response,
        input  spi_dout, spi_buffer_full, spi_buffer_empty, spi_data_avail
    );

    modport slave (
        input  spi_wr, spi_rd, spi_addr, spi_din, spi_ignore_response,
        output spi_dout, spi_buffer_full, spi_buffer_empty, spi_data_avail
    );
endinterface

// File: rtl/spi_master_mmio_sync_fifo.sv
// Show-ahead synchronous FIFO with count-based flags; a push and a pop in the
// same cycle both take effect. Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
endmodule

// File: rtl/spi_master_mmio.sv
// MMIO SPI master (mode 0, MSB first): stores fill a TX FIFO, the shift engine
// clocks bytes out on SCLK/MOSI and lands captured MISO bytes in an RX FIFO.
module spi_master_mmio
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_mmio_if.slave   bus,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               cs_n,
    output spi_state_t         dbg_state
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    spi_state_t    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    spi_tx_entry_t tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;

    spi_tx_entry_t tx_head;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [CW-1:0] tx_count;
    logic [7:0]    rx_head;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [CW-1:0] rx_count;
    logic          div_last, tx_avail, can_start, can_next;

    assign tx_push = bus.spi_wr && (bus.spi_addr == SPI_DATA_ADDR);
    assign rx_pop  = bus.spi_rd && (bus.spi_addr == SPI_DATA_ADDR);

    sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push),
        .wr_data({bus.spi_ignore_response, bus.spi_din}),
        .pop(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .wr_data(rx_q),
        .pop(rx_pop), .rd_data(rx_head), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    assign div_last  = (div_q == DIV_LAST);
    assign tx_avail  = (tx_count != '0);
    assign can_start = tx_avail && (tx_head.ign || !rx_full);
    // In DONE our own push has not landed yet, so reserve its slot before chaining.
    assign can_next  = tx_avail && (tx_head.ign ||
                       ((rx_count + CW'(!tx_q.ign)) < CW'(FIFO_DEPTH)));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_start) begin
                    tx_pop  = 1'b1;
                    tx_d    = tx_head;
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_head.data[7];
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP, HIGH, LOW: begin
                if (!div_last) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (state_q == HIGH) begin
                        sclk_d  = 1'b0;
                        state_d = LOW;
                        if (bit_q != 3'd7) mosi_d = tx_q.data[3'd6 - bit_q];
                    end else if (state_q == LOW && bit_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        if (state_q == LOW) bit_d = bit_q + 1'b1;
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[6:0], miso};
                        state_d = HIGH;
                    end
                end
            end
            DONE: begin
                rx_push = !tx_q.ign;
                if (can_next) begin
                    tx_pop  = 1'b1;
                    tx_d    = tx_head;
                    mosi_d  = tx_head.data[7];
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end else begin
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end

    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
    assign dbg_state = state_q;

    assign bus.spi_dout         = rx_empty ? 8'h00 : rx_head;
    assign bus.spi_buffer_full  = tx_full;
    assign bus.spi_buffer_empty = tx_empty && (state_q == IDLE);
    assign bus.spi_data_avail   = !rx_empty;
endmodule

// File: tb/tb_spi_master_mmio.sv
// Directed bench for spi_master_mmio with MISO looped back to MOSI, CLK_DIV=2
// and 8-deep FIFOs; RX bytes are checked against an expected queue.
module tb_spi_master_mmio;
    import spi_pkg::*;

    localparam int CD = 2;
    localparam int FD = 8;

    logic       clk;
    logic       rst;
    logic       sclk, mosi, miso, cs_n;
    spi_state_t dbg_state;

    spi_master_mmio_if mmio ();

    spi_master_mmio #(.CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .bus(mmio), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n), .dbg_state(dbg_state)
    );

    assign miso = mosi;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- line monitor ----------------
    logic [63:0] mon_bits;
    int          mon_rises;
    int          mon_cs_rises;
    logic        mon_prev_sclk = 1'b0;
    logic        mon_prev_cs   = 1'b1;

    always @(negedge clk) begin
        if (sclk && !mon_prev_sclk) begin
            mon_bits  = {mon_bits[62:0], mosi};
            mon_rises = mon_rises + 1;
        end
        if (cs_n && !mon_prev_cs) mon_cs_rises = mon_cs_rises + 1;
        mon_prev_sclk = sclk;
        mon_prev_cs   = cs_n;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_bits     = '0;
        mon_rises    = 0;
        mon_cs_rises = 0;
    endtask

    task automatic bus_write(input logic [7:0] d, input logic ign);
        mmio.spi_wr              = 1'b1;
        mmio.spi_addr            = SPI_DATA_ADDR;
        mmio.spi_din             = d;
        mmio.spi_ignore_response = ign;
        step();
        mmio.spi_wr              = 1'b0;
        mmio.spi_ignore_response = 1'b0;
    endtask

    task automatic bus_read(input string tag);
        logic [7:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check_eq(tag, {56'h0, mmio.spi_dout}, {56'h0, exp});
        mmio.spi_rd   = 1'b1;
        mmio.spi_addr = SPI_DATA_ADDR;
        step();
        mmio.spi_rd   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && !cs_n; i++) step();
        check_eq(tag, {63'h0, cs_n}, 64'h1);
        step();
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] tbl_a [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    initial begin
        int w_cyc;
        int avail_at;
        int n_edge;
        logic prev;

        mmio.spi_wr = 1'b0;
        mmio.spi_rd = 1'b0;
        mmio.spi_addr = 1'b0;
        mmio.spi_din = 8'h00;
        mmio.spi_ignore_response = 1'b0;
        mon_clear();
        rst = 1'b1;
        repeat (3) step();
        check_eq("rst_sclk",  {63'h0, sclk}, 64'h0);
        check_eq("rst_cs_n",  {63'h0, cs_n}, 64'h1);
        check_eq("rst_mosi",  {63'h0, mosi}, 64'h0);
        check_eq("rst_dout",  {56'h0, mmio.spi_dout}, 64'h0);
        check_eq("rst_full",  {63'h0, mmio.spi_buffer_full}, 64'h0);
        check_eq("rst_empty", {63'h0, mmio.spi_buffer_empty}, 64'h1);
        check_eq("rst_avail", {63'h0, mmio.spi_data_avail}, 64'h0);
        rst = 1'b0;
        repeat (2) step();

        // 0xA5 loopback with cycle-exact cs_n / data_avail timing
        mon_clear();
        w_cyc = cyc;
        bus_write(8'hA5, 1'b0);
        exp_q.push_back(8'hA5);
        check_eq("a5_cs_c1", {63'h0, cs_n}, 64'h1);
        step();
        check_eq("a5_cs_c2", {63'h0, cs_n}, 64'h0);
        avail_at = -1;
        for (int i = 0; i < 80 && !cs_n; i++) begin
            step();
            if (mmio.spi_data_avail && avail_at < 0) avail_at = cyc - w_cyc;
        end
        check_eq("a5_avail_cycle", 64'(avail_at), 64'd37);
        step();
        check_eq("a5_mosi_bits", {56'h0, mon_bits[7:0]}, 64'hA5);
        check_eq("a5_rises", 64'(mon_rises), 64'd8);
        bus_read("a5_read");
        check_eq("a5_avail_after", {63'h0, mmio.spi_data_avail}, 64'h0);

        // ignored response
        mon_clear();
        bus_write(8'h3C, 1'b1);
        step();
        check_eq("ign_cs_low", {63'h0, cs_n}, 64'h0);
        check_eq("ign_busy", {63'h0, mmio.spi_buffer_empty}, 64'h0);
        wait_idle("ign_timeout", 80);
        check_eq("ign_mosi_bits", {56'h0, mon_bits[7:0]}, 64'h3C);
        check_eq("ign_empty", {63'h0, mmio.spi_buffer_empty}, 64'h1);
        check_eq("ign_avail", {63'h0, mmio.spi_data_avail}, 64'h0);

        // fill RX with 8 bytes, back-to-back
        mon_clear();
        for (int i = 0; i < 8; i++) begin
            bus_write(tbl_a[i], 1'b0);
            exp_q.push_back(tbl_a[i]);
        end
        wait_idle("fill_timeout", 400);
        check_eq("fill_bits", mon_bits, 64'h0123456789ABCDEF);
        check_eq("fill_rises", 64'(mon_rises), 64'd64);
        check_eq("fill_cs_once", 64'(mon_cs_rises), 64'd1);

        // RX full: one more non-ignored byte must stall until a read
        bus_write(8'h5A, 1'b0);
        repeat (10) step();
        check_eq("stall_cs_high", {63'h0, cs_n}, 64'h1);
        check_eq("stall_not_empty", {63'h0, mmio.spi_buffer_empty}, 64'h0);
        mon_clear();
        bus_read("stall_read");
        exp_q.push_back(8'h5A);
        step();
        check_eq("stall_restart", {63'h0, cs_n}, 64'h0);
        wait_idle("stall_timeout", 80);
        check_eq("stall_bits", {56'h0, mon_bits[7:0]}, 64'h5A);

        // TX overflow while stalled: the 9th byte is dropped
        for (int i = 0; i < 9; i++) bus_write(8'hC0 + 8'(i), 1'b0);
        check_eq("ovf_full", {63'h0, mmio.spi_buffer_full}, 64'h1);
        check_eq("ovf_cs_high", {63'h0, cs_n}, 64'h1);
        mon_clear();
        for (int i = 0; i < 8; i++) bus_read("drain_read");
        for (int i = 0; i < 8; i++) exp_q.push_back(8'hC0 + 8'(i));
        wait_idle("ovf_timeout", 600);
        check_eq("ovf_bits", mon_bits, 64'hC0C1C2C3C4C5C6C7);
        check_eq("ovf_rises", 64'(mon_rises), 64'd64);
        check_eq("ovf_cs_once", 64'(mon_cs_rises), 64'd1);
        for (int i = 0; i < 8; i++) bus_read("ovf_read");
        check_eq("ovf_avail_after", {63'h0, mmio.spi_data_avail}, 64'h0);

        // status-register accesses have no side effects
        bus_write(8'h11, 1'b0);
        exp_q.push_back(8'h11);
        step();
        wait_idle("stat_timeout", 80);
        mmio.spi_rd = 1'b1;
        mmio.spi_addr = SPI_STAT_ADDR;
        step();
        mmio.spi_rd = 1'b0;
        mmio.spi_wr = 1'b1;
        mmio.spi_din = 8'h77;
        step();
        mmio.spi_wr = 1'b0;
        mmio.spi_addr = SPI_DATA_ADDR;
        step();
        check_eq("stat_avail", {63'h0, mmio.spi_data_avail}, 64'h1);
        check_eq("stat_no_push", {63'h0, mmio.spi_buffer_empty}, 64'h1);
        bus_read("stat_read");
        check_eq("stat_avail_after", {63'h0, mmio.spi_data_avail}, 64'h0);

        // reset at the 4th SCLK rising edge aborts the transfer
        bus_write(8'hF0, 1'b0);
        bus_write(8'h0F, 1'b0);
        n_edge = 0;
        prev = sclk;
        for (int i = 0; i < 200 && n_edge < 4; i++) begin
            step();
            if (sclk && !prev) n_edge++;
            prev = sclk;
        end
        check_eq("mid_edge4", 64'(n_edge), 64'd4);
        rst = 1'b1;
        #1;
        check_eq("mid_cs_n", {63'h0, cs_n}, 64'h1);
        check_eq("mid_sclk", {63'h0, sclk}, 64'h0);
        check_eq("mid_empty", {63'h0, mmio.spi_buffer_empty}, 64'h1);
        check_eq("mid_full", {63'h0, mmio.spi_buffer_full}, 64'h0);
        check_eq("mid_avail", {63'h0, mmio.spi_data_avail}, 64'h0);
        check_eq("mid_dout", {56'h0, mmio.spi_dout}, 64'h0);
        exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        check_eq("post_rst_cs_n", {63'h0, cs_n}, 64'h1);
        check_eq("post_rst_empty", {63'h0, mmio.spi_buffer_empty}, 64'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
